huff_phase_ctrl: RTL
====================

Name: huff_phase_ctrl

Overview:
Sequences one Huffman compression pass.
- Accepts a symbol stream from the input source.
- Drives the symbol-frequency counter: clear, per-symbol increment, finish.
- Buffers the accepted symbols, launches the tree builder, and waits for it to complete.
- Replays the buffered symbols to the encoder over a valid/ready handshake.
- Sits between the input source, the frequency counter, the tree builder and the encoder.

Parameters:
- DEPTH_LOG2, 8, log2 of the maximum number of symbols per message (buffer depth 2^DEPTH_LOG2 = 256).
- SYM_W, 4, width of a symbol field.
- NSYM, 10, number of valid symbols (0..NSYM-1); any value >= NSYM is the terminator.

Ports:
- Clk_in  in  1  clock; all logic on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  begin a pass; sampled only in IDLE.
- In_valid  in  1  input symbol valid.
- In_data  in  SYM_W  input symbol or terminator.
- In_ready  out  1  controller accepts In_data.
- Cnt_clr  out  1  clear-counters strobe.
- Cnt_inc  out  1  increment strobe for symbol Cnt_sym.
- Cnt_sym  out  SYM_W  symbol to count.
- Cnt_fin  out  1  counting-complete strobe.
- Build_start  out  1  tree-builder launch strobe.
- Build_done  in  1  tree builder complete; level or pulse.
- Enc_valid  out  1  replay symbol valid.
- Enc_data  out  SYM_W  replay symbol.
- Enc_last  out  1  marks the final replay symbol.
- Enc_ready  in  1  encoder accepts Enc_data.
- Sym_total  out  DEPTH_LOG2+1  number of symbols stored in the current or most recent pass.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pass-complete pulse.

Behaviour:
- Storage: register file of 2^DEPTH_LOG2 x SYM_W with synchronous write and combinational read. Contents are not reset.
- FSM states: IDLE, CLEAR, COUNT, BUILD_REQ, BUILD_WAIT, REPLAY, DONE.
- Reset: Rst=1 forces, immediately and asynchronously, state=IDLE, wptr=0, rptr=0, Sym_total=0, and every output 0. Applies mid-pass too; the pass is abandoned with no Done.
- IDLE:
  - Start=1 -> CLEAR.
  - Start in any other state is ignored.
- CLEAR (1 cycle):
  - Cnt_clr=1.
  - wptr and Sym_total load 0.
  - -> COUNT.
- COUNT:
  - In_ready=1. Handshake = In_valid & In_ready.
  - Data symbol (In_data < NSYM) on handshake:
    - Cnt_inc=1 and Cnt_sym=In_data in the same cycle (combinational from the handshake).
    - buf[wptr]<=In_data, wptr++, Sym_total++.
    - If this is the 2^DEPTH_LOG2-th symbol (Sym_total becomes 256) -> BUILD_REQ; In_ready is 0 from the next cycle.
  - Terminator (In_data >= NSYM) on handshake:
    - Consumed; not stored, not counted, Cnt_inc=0.
    - -> BUILD_REQ if Sym_total > 0.
    - -> DONE if Sym_total == 0 (empty message: no Cnt_fin, no Build_start, no replay).
  - In_valid gaps are allowed; no timeout.
- BUILD_REQ (1 cycle):
  - Cnt_fin=1 and Build_start=1.
  - Always at least one cycle after the last Cnt_inc.
  - -> BUILD_WAIT.
- BUILD_WAIT:
  - Build_done=1 -> REPLAY with rptr=0.
  - Build_done in any other state is ignored.
- REPLAY:
  - Enc_valid=1, Enc_data=buf[rptr], Enc_last=(rptr==Sym_total-1).
  - Enc_valid & Enc_ready: rptr++; if Enc_last -> DONE.
  - While Enc_valid & ~Enc_ready: Enc_data and Enc_last held stable.
  - Each stored symbol is delivered exactly once, in arrival order.
- DONE (1 cycle): Done=1 -> IDLE.
- Sym_total holds its value in IDLE until the next CLEAR. At 256 its MSB is set; it never wraps.
- All strobes (Cnt_clr, Cnt_inc, Cnt_fin, Build_start, Done) are single-cycle, except Cnt_inc, which repeats once per accepted data symbol.
- Latency, Start to Cnt_clr: 1 cycle (IDLE -> CLEAR).

Test Plan:
1. Start; feed 3,3,7,0 then 0xA. Required: 4 Cnt_inc pulses with Cnt_sym 3,3,7,0; Sym_total=4; one Cnt_fin/Build_start pulse. Assert Build_done 5 cycles later: Enc stream 3,3,7,0 with Enc_last only on 0, then one Done pulse, Busy=0.
2. Feed 256 symbols (i mod 10), no terminator. Required: In_ready=0 after the 256th accept; Sym_total=256 (9'h100); replay of 256 symbols, Enc_last on the 256th (value 5).
3. Start, first symbol 0xF. Required: Cnt_clr pulse, no Cnt_inc, no Cnt_fin, no Build_start, no Enc_valid; Done pulse; Sym_total=0.
4. Replay with Enc_ready toggling 1,0,1,0 and random In_valid gaps during COUNT. Required: Enc_data/Enc_last stable while stalled; no symbol dropped or duplicated; counts match the accepted data symbols.
5. Start pulsed during BUILD_WAIT and REPLAY; Build_done pulsed during COUNT. Required: both ignored; the pass completes normally with a single Done.
6. Rst=1 asserted mid-REPLAY, between clock edges. Required: Enc_valid, Busy and every other output 0 immediately and Sym_total=0. After release, a new Start runs a full pass correctly (repeat scenario 1).

Source files
------------

// File: rtl/huff_phase_ctrl.sv
// Huffman pass sequencer: collects a symbol message, drives the frequency
// counter and tree builder, then replays the stored message to the encoder.
module huff_phase_ctrl #(
   parameter int DEPTH_LOG2 = 8,
   parameter int SYM_W      = 4,
   parameter int NSYM       = 10
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [SYM_W-1:0]      in_data,
   output logic                  in_ready,
   output logic                  cnt_clr,
   output logic                  cnt_inc,
   output logic [SYM_W-1:0]      cnt_sym,
   output logic                  cnt_fin,
   output logic                  build_start,
   input  logic                  build_done,
   output logic                  enc_valid,
   output logic [SYM_W-1:0]      enc_data,
   output logic                  enc_last,
   input  logic                  enc_ready,
   output logic [DEPTH_LOG2:0]   sym_total,
   output logic                  busy,
   output logic                  done
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_CLEAR      = 3'd1;
   localparam logic [2:0] S_COUNT      = 3'd2;
   localparam logic [2:0] S_BUILD_REQ  = 3'd3;
   localparam logic [2:0] S_BUILD_WAIT = 3'd4;
   localparam logic [2:0] S_REPLAY     = 3'd5;
   localparam logic [2:0] S_DONE       = 3'd6;

   localparam int                  DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [SYM_W:0]      NSYM_L = (SYM_W+1)'(NSYM);
   localparam logic [DEPTH_LOG2:0] FULL_M1 = (DEPTH_LOG2+1)'(DEPTH - 1);
   localparam logic [DEPTH_LOG2:0] ONE_T   = (DEPTH_LOG2+1)'(1);

   logic [2:0]            state, state_nxt;
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [SYM_W-1:0]      mem [DEPTH];
   logic                  hs, is_data;

   assign is_data = {1'b0, in_data} < NSYM_L;
   assign hs      = in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (start) state_nxt = S_CLEAR;
         S_CLEAR:      state_nxt = S_COUNT;
         S_COUNT:
            if (hs) begin
               if (is_data) begin
                  if (sym_total == FULL_M1) state_nxt = S_BUILD_REQ;
               end else begin
                  state_nxt = (sym_total != '0) ? S_BUILD_REQ : S_DONE;
               end
            end
         S_BUILD_REQ:  state_nxt = S_BUILD_WAIT;
         S_BUILD_WAIT: if (build_done) state_nxt = S_REPLAY;
         S_REPLAY:     if (enc_ready && enc_last) state_nxt = S_DONE;
         S_DONE:       state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wptr      <= '0;
         rptr      <= '0;
         sym_total <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_CLEAR: begin
               wptr      <= '0;
               sym_total <= '0;
            end
            S_COUNT:
               if (hs && is_data) begin
                  wptr      <= wptr + 1'b1;
                  sym_total <= sym_total + ONE_T;
               end
            S_BUILD_WAIT: if (build_done) rptr <= '0;
            S_REPLAY:     if (enc_ready) rptr <= rptr + 1'b1;
            default: ;
         endcase
      end
   end

   // message store is not reset; only slots below sym_total are ever read
   always_ff @(posedge clk_in) begin
      if (state == S_COUNT && hs && is_data) mem[wptr] <= in_data;
   end

   assign in_ready    = (state == S_COUNT);
   assign cnt_clr     = (state == S_CLEAR);
   assign cnt_inc     = hs && is_data;
   assign cnt_sym     = cnt_inc ? in_data : '0;
   assign cnt_fin     = (state == S_BUILD_REQ);
   assign build_start = (state == S_BUILD_REQ);
   assign enc_valid   = (state == S_REPLAY);
   assign enc_data    = enc_valid ? mem[rptr] : '0;
   assign enc_last    = enc_valid && ({1'b0, rptr} == (sym_total - ONE_T));
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);

endmodule
